// File: rtl/ser_shift_stage.sv
// Purpose : parallel-to-serial shifter with a one-word holding register for gapless word streaming.
// Latency : first bit of an accepted word appears on SOUT in the cycle after the accepting edge.
// Backpressure: DIN_RDY drops while the holding register is full; it is never a function of DIN_VLD.
module ser_shift_stage #(
   parameter int   WIDTH     = 8,
   parameter logic INIT      = 1'b1,
   parameter logic MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VLD,
   output logic             DIN_RDY,
   output logic             SOUT,
   output logic             SOUT_VLD,
   output logic             SOF,
   output logic             IDLE
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             rdy_en_q, rdy_en_d;
   logic             xfer;

   // Ready depends only on registered state; a transfer is ready and valid together.
   always_comb begin
      DIN_RDY = rdy_en_q & ~hold_full_q;
      xfer    = DIN_VLD & DIN_RDY;
   end

   // Next-state logic: load, shift, reload from HOLD or direct input at the last bit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rdy_en_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               sr_d    = DIN;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_q != CNT_LAST) begin
               // Move the next bit toward the output end of the register.
               sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
               cnt_d = cnt_q + CW'(1);
               if (xfer) begin
                  hold_d      = DIN;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               // Last bit: the buffered word follows with no gap.
               sr_d        = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else if (xfer) begin
               // Last bit with an empty HOLD: take the incoming word directly.
               sr_d  = DIN;
               cnt_d = '0;
            end else begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers; reset aborts any word in flight and empties HOLD.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rdy_en_q    <= rdy_en_d;
      end
   end

   // Serial outputs decoded from registered state only.
   always_comb begin
      SOUT     = INIT;
      SOUT_VLD = 1'b0;
      SOF      = 1'b0;
      IDLE     = (state_q == S_IDLE) & ~hold_full_q;
      if (state_q == S_SHIFT) begin
         SOUT     = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
         SOUT_VLD = 1'b1;
         SOF      = (cnt_q == '0);
      end
   end

endmodule
